// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : Shared VGA timing constants, widths and sync bundle type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

  localparam int COORD_W  = 10;
  localparam int COLOUR_W = 4;

  // 640x480@60 defaults
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } sync_t;

  function automatic int h_total(input int act, input int fp, input int sw, input int bp);
    return act + fp + sw + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sw, input int bp);
    return act + fp + sw + bp;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_output_if.sv
// ============================================================================
// Module   : vga_output_if
// Brief    : Pixel timing, colour return and DAC-side signals of vga_output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_output_if;
  import vga_timing_pkg::*;

  logic                pix_ce;
  logic [COORD_W-1:0]  x;
  logic [COORD_W-1:0]  y;
  logic                active;
  logic                frame_end;
  logic [COLOUR_W-1:0] red;
  logic [COLOUR_W-1:0] green;
  logic [COLOUR_W-1:0] blue;
  logic [COLOUR_W-1:0] vga_r;
  logic [COLOUR_W-1:0] vga_g;
  logic [COLOUR_W-1:0] vga_b;
  logic                vga_hs;
  logic                vga_vs;

  modport master (
    output pix_ce, x, y, active, frame_end,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs,
    input  red, green, blue
  );

  modport slave (
    input  pix_ce, x, y, active, frame_end,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs,
    output red, green, blue
  );

endinterface

`default_nettype wire

// File: rtl/vga_output_sync_delay_line.sv
// ============================================================================
// Module   : sync_delay_line
// Brief    : DEPTH-stage shift register with clock enable and sync reset value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_delay_line #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             i_ce,
  input  wire logic [WIDTH-1:0] i_d,
  output logic      [WIDTH-1:0] o_q
);

  logic [DEPTH*WIDTH-1:0] r_sr;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (!reset_n)  r_sr <= RST_VAL;
        else if (i_ce) r_sr <= i_d;
      end
    end else begin : g_many
      always_ff @(posedge clk) begin
        if (!reset_n)  r_sr <= {DEPTH{RST_VAL}};
        else if (i_ce) r_sr <= {r_sr[(DEPTH-1)*WIDTH-1:0], i_d};
      end
    end
  endgenerate

  assign o_q = r_sr[DEPTH*WIDTH-1 -: WIDTH];

endmodule

`default_nettype wire

// File: rtl/vga_output.sv
// ============================================================================
// Module   : vga_output
// Brief    : VGA raster timing, coordinates, frame strobe and aligned DAC outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_output
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV    = 2,
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FP       = DEF_H_FP,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BP       = DEF_H_BP,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FP       = DEF_V_FP,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BP       = DEF_V_BP,
  parameter int   PIPE_DELAY = 2,
  parameter logic SYNC_POL   = 1'b0
) (
  input wire logic      clk,
  input wire logic      reset_n,
  vga_output_if.master  io_vga
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   c_div_last = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] c_h_last   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] c_v_last   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] c_h_active = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] c_v_active = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] c_v_fe_y   = COORD_W'(V_ACTIVE - 1);
  localparam logic [COORD_W-1:0] c_hs_start = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] c_hs_end   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] c_vs_start = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] c_vs_end   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0]    r_div;
  logic                r_pix_ce;
  logic                r_run;
  logic [COORD_W-1:0]  r_x;
  logic [COORD_W-1:0]  r_y;
  logic                r_frame_end;
  logic [COLOUR_W-1:0] r_vga_r;
  logic [COLOUR_W-1:0] r_vga_g;
  logic [COLOUR_W-1:0] r_vga_b;
  logic                r_vga_hs;
  logic                r_vga_vs;

  logic [DIV_W-1:0]    w_div_next;
  logic                w_h_last;
  logic                w_v_last;
  sync_t               w_dl_in;
  sync_t               w_dl_out;

  assign w_div_next = (r_div == c_div_last) ? '0 : r_div + DIV_W'(1);
  assign w_h_last   = (r_x == c_h_last);
  assign w_v_last   = (r_y == c_v_last);

  // pix_ce is registered so it is low in every reset cycle, including CLK_DIV=1
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_div    <= '0;
      r_pix_ce <= 1'b0;
      r_run    <= 1'b0;
    end else begin
      r_div    <= w_div_next;
      r_pix_ce <= (w_div_next == c_div_last);
      r_run    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_x         <= '0;
      r_y         <= '0;
      r_frame_end <= 1'b0;
    end else begin
      r_frame_end <= r_pix_ce && w_h_last && (r_y == c_v_fe_y);
      if (r_pix_ce) begin
        r_x <= w_h_last ? '0 : r_x + COORD_W'(1);
        if (w_h_last) r_y <= w_v_last ? '0 : r_y + COORD_W'(1);
      end
    end
  end

  assign w_dl_in.hs     = (r_x >= c_hs_start && r_x < c_hs_end) ? SYNC_POL : ~SYNC_POL;
  assign w_dl_in.vs     = (r_y >= c_vs_start && r_y < c_vs_end) ? SYNC_POL : ~SYNC_POL;
  assign w_dl_in.active = r_run && (r_x < c_h_active) && (r_y < c_v_active);

  sync_delay_line #(
    .DEPTH   (PIPE_DELAY),
    .WIDTH   ($bits(sync_t)),
    .RST_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
  ) u_sync_dl (
    .clk     (clk),
    .reset_n (reset_n),
    .i_ce    (r_pix_ce),
    .i_d     (w_dl_in),
    .o_q     (w_dl_out)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vga_r  <= '0;
      r_vga_g  <= '0;
      r_vga_b  <= '0;
      r_vga_hs <= ~SYNC_POL;
      r_vga_vs <= ~SYNC_POL;
    end else if (r_pix_ce) begin
      r_vga_r  <= w_dl_out.active ? io_vga.red   : '0;
      r_vga_g  <= w_dl_out.active ? io_vga.green : '0;
      r_vga_b  <= w_dl_out.active ? io_vga.blue  : '0;
      r_vga_hs <= w_dl_out.hs;
      r_vga_vs <= w_dl_out.vs;
    end
  end

  assign io_vga.pix_ce    = r_pix_ce;
  assign io_vga.x         = r_x;
  assign io_vga.y         = r_y;
  assign io_vga.active    = w_dl_in.active;
  assign io_vga.frame_end = r_frame_end;
  assign io_vga.vga_r     = r_vga_r;
  assign io_vga.vga_g     = r_vga_g;
  assign io_vga.vga_b     = r_vga_b;
  assign io_vga.vga_hs    = r_vga_hs;
  assign io_vga.vga_vs    = r_vga_vs;

endmodule

`default_nettype wire

// File: tb/tb_vga_output.sv
// ============================================================================
// Module   : tb_vga_output
// Brief    : Scoreboard bench: unit 0 (CLK_DIV=2, PIPE_DELAY=2), unit 1 (1, 1), reduced raster.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_output;
  import vga_timing_pkg::*;

  localparam int HA = 20, HFP = 4, HSY = 6, HBP = 5;
  localparam int VA = 10, VFP = 2, VSY = 2, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hs;
    logic       vs;
  } vo_t;

  typedef struct packed {
    logic       pce;
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       fe;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hs;
    logic       vs;
  } ob_t;

  localparam vo_t IDLE = '{r: 4'h0, g: 4'h0, b: 4'h0, hs: 1'b1, vs: 1'b1};

  logic clk = 1'b0;
  logic rst0_n, rst1_n;
  always #5 clk = ~clk;

  vga_output_if vif0();
  vga_output_if vif1();

  vga_output #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .PIPE_DELAY(2), .SYNC_POL(1'b0)
  ) u_dut0 (.clk(clk), .reset_n(rst0_n), .io_vga(vif0.master));

  vga_output #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .PIPE_DELAY(1), .SYNC_POL(1'b0)
  ) u_dut1 (.clk(clk), .reset_n(rst1_n), .io_vga(vif1.master));

  int n_checks = 0;
  int n_fail   = 0;

  int       m_div [2];
  int       m_x   [2];
  int       m_y   [2];
  bit       m_pce [2];
  bit       m_run [2];
  bit       m_fe  [2];
  bit       m_valid [2];
  logic [2:0] m_dl [2][2];
  int       m_rx  [2][2];
  vo_t      cur   [2];
  vo_t      sb0[$];
  vo_t      sb1[$];
  bit       rst_req [2];
  bit       force_f;
  int       hl, vl, fe_cnt, hs_runs, vs_runs;

  function automatic int cd(input int u);
    return (u == 0) ? 2 : 1;
  endfunction

  function automatic int pd(input int u);
    return (u == 0) ? 2 : 1;
  endfunction

  function automatic ob_t grab(input int u);
    ob_t o;
    if (u == 0) o = '{vif0.pix_ce, vif0.x, vif0.y, vif0.active, vif0.frame_end,
                      vif0.vga_r, vif0.vga_g, vif0.vga_b, vif0.vga_hs, vif0.vga_vs};
    else        o = '{vif1.pix_ce, vif1.x, vif1.y, vif1.active, vif1.frame_end,
                      vif1.vga_r, vif1.vga_g, vif1.vga_b, vif1.vga_hs, vif1.vga_vs};
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_colour(input int u, input logic [3:0] rv);
    if (u == 0) begin
      vif0.red = rv; vif0.green = rv; vif0.blue = ~rv;
    end else begin
      vif1.red = rv; vif1.green = rv; vif1.blue = ~rv;
    end
  endtask

  task automatic check_unit(input int u);
    ob_t o;
    vo_t e;
    string p;
    o = grab(u);
    p = $sformatf("u%0d_", u);
    if (m_valid[u]) begin
      if (u == 0 && sb0.size() > 0) cur[0] = sb0.pop_front();
      if (u == 1 && sb1.size() > 0) cur[1] = sb1.pop_front();
      e = cur[u];
      chk({p, "pix_ce"},    32'(o.pce), 32'(m_pce[u]));
      chk({p, "x"},         32'(o.x),   32'(m_x[u]));
      chk({p, "y"},         32'(o.y),   32'(m_y[u]));
      chk({p, "active"},    32'(o.act), 32'(m_run[u] && m_x[u] < HA && m_y[u] < VA));
      chk({p, "frame_end"}, 32'(o.fe),  32'(m_fe[u]));
      chk({p, "vga_r"},     32'(o.r),   32'(e.r));
      chk({p, "vga_g"},     32'(o.g),   32'(e.g));
      chk({p, "vga_b"},     32'(o.b),   32'(e.b));
      chk({p, "vga_hs"},    32'(o.hs),  32'(e.hs));
      chk({p, "vga_vs"},    32'(o.vs),  32'(e.vs));
    end
  endtask

  // Independent sync-width and frame-strobe measurements on unit 0
  task automatic stats0();
    if (vif0.frame_end === 1'b1) begin
      fe_cnt++;
      chk("u0_fe_pos", {12'd0, vif0.x, vif0.y}, {12'd0, 10'd0, 10'(VA)});
    end
    if (vif0.pix_ce === 1'b1) begin
      if (vif0.vga_hs === 1'b0) hl++;
      else begin
        if (hl != 0) begin chk("u0_hs_width", 32'(hl), 32'(HSY)); hs_runs++; end
        hl = 0;
      end
      if (vif0.vga_vs === 1'b0) vl++;
      else begin
        if (vl != 0) begin chk("u0_vs_width", 32'(vl), 32'(VSY * HT)); vs_runs++; end
        vl = 0;
      end
    end
  endtask

  task automatic step_unit(input int u, input bit rn);
    logic [3:0] rv;
    logic [2:0] tail;
    logic       act;
    vo_t        e;
    if (u == 0) rst0_n = rn; else rst1_n = rn;
    if (!rn) begin
      m_valid[u] = 1'b1;
      m_div[u] = 0; m_pce[u] = 1'b0; m_run[u] = 1'b0; m_fe[u] = 1'b0;
      m_x[u] = 0; m_y[u] = 0;
      for (int s = 0; s < 2; s++) begin
        m_dl[u][s] = 3'b110;
        m_rx[u][s] = 0;
      end
      if (u == 0) begin sb0.delete(); sb0.push_back(IDLE); end
      else        begin sb1.delete(); sb1.push_back(IDLE); end
    end else if (m_valid[u]) begin
      if (m_pce[u]) begin
        // red for this tick is the x seen PIPE_DELAY ticks earlier
        rv = force_f ? 4'hF : 4'(m_rx[u][pd(u)-1]);
        m_rx[u][1] = m_rx[u][0];
        m_rx[u][0] = m_x[u];
        drive_colour(u, rv);
        tail = m_dl[u][pd(u)-1];
        e.hs = tail[2];
        e.vs = tail[1];
        e.r  = tail[0] ? rv  : 4'h0;
        e.g  = tail[0] ? rv  : 4'h0;
        e.b  = tail[0] ? ~rv : 4'h0;
        if (u == 0) sb0.push_back(e); else sb1.push_back(e);
        act = m_run[u] && m_x[u] < HA && m_y[u] < VA;
        m_dl[u][1] = m_dl[u][0];
        m_dl[u][0] = {!(m_x[u] >= HA + HFP && m_x[u] < HA + HFP + HSY),
                      !(m_y[u] >= VA + VFP && m_y[u] < VA + VFP + VSY), act};
        m_fe[u] = (m_x[u] == HT - 1) && (m_y[u] == VA - 1);
        if (m_x[u] == HT - 1) begin
          m_x[u] = 0;
          m_y[u] = (m_y[u] == VT - 1) ? 0 : m_y[u] + 1;
        end else begin
          m_x[u] = m_x[u] + 1;
        end
      end else begin
        m_fe[u] = 1'b0;
      end
      m_run[u] = 1'b1;
      m_div[u] = (m_div[u] == cd(u) - 1) ? 0 : m_div[u] + 1;
      m_pce[u] = (m_div[u] == cd(u) - 1);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_unit(0);
    check_unit(1);
    stats0();
    if (!rst_req[0]) begin hl = 0; vl = 0; end
    step_unit(0, rst_req[0]);
    step_unit(1, rst_req[1]);
  endtask

  initial begin
    bit found;
    rst0_n = 1'b0; rst1_n = 1'b0;
    rst_req[0] = 1'b0; rst_req[1] = 1'b0;
    force_f = 1'b0;
    m_valid[0] = 1'b0; m_valid[1] = 1'b0;
    cur[0] = IDLE; cur[1] = IDLE;
    hl = 0; vl = 0; fe_cnt = 0; hs_runs = 0; vs_runs = 0;
    drive_colour(0, 4'h0);
    drive_colour(1, 4'h0);

    repeat (4) cycle();
    chk("u0_rst_hs",  32'(vif0.vga_hs), 32'd1);
    chk("u0_rst_vs",  32'(vif0.vga_vs), 32'd1);
    chk("u0_rst_r",   32'(vif0.vga_r),  32'd0);
    chk("u0_rst_pce", 32'(vif0.pix_ce), 32'd0);

    // Two clean frames from release
    rst_req[0] = 1'b1;
    fe_cnt = 0;
    repeat (2 * 2 * FT + 20) cycle();
    chk("u0_fe_count", 32'(fe_cnt), 32'd2);

    // Colour forced to F: blanking must still hold outside the active area
    force_f = 1'b1;
    repeat (2 * FT) cycle();
    force_f = 1'b0;

    // Mid-frame reset inside the active area
    found = 1'b0;
    for (int i = 0; i < 4 * FT; i++) begin
      if (m_x[0] == 12 && m_y[0] == 5 && m_pce[0]) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    chk("u0_reach_mid", 32'(found), 32'd1);
    rst_req[0] = 1'b0;
    repeat (3) cycle();
    rst_req[0] = 1'b1;
    repeat (300) cycle();

    // Unit 1: CLK_DIV=1, PIPE_DELAY=1
    rst_req[1] = 1'b1;
    repeat (2 * FT + 20) cycle();

    chk("u0_hs_runs_seen", 32'(hs_runs > 0), 32'd1);
    chk("u0_vs_runs_seen", 32'(vs_runs > 0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
